// File: rtl/ldpc_pkg.sv
// Shared definitions for the min-sum LDPC decoder datapath:
// message width, magnitude saturation limit and the variable-node FSM states.
package ldpc_pkg;

  localparam int W       = 5;
  localparam int MAG_MAX = 15;

  typedef enum logic {
    ACC,
    EMIT
  } state_t;

endpackage

// File: rtl/sat_t_to_s.sv
// Combinational two's complement to saturated sign-magnitude converter.
// Values outside [-MAG_MAX, +MAG_MAX] clamp to the limit with their sign kept.
module sat_t_to_s
  import ldpc_pkg::*;
#(
  parameter int IW = 9,
  parameter int OW = W
) (
  input  logic signed [IW-1:0] din,
  output logic        [OW-1:0] dout
);

  localparam logic signed [IW-1:0] HI = IW'(MAG_MAX);
  localparam logic signed [IW-1:0] LO = -HI;

  logic [OW-2:0] mag;

  // Zero falls out of the in-range branch with a clear sign bit.
  always_comb begin
    mag = (OW-1)'(din[IW-1] ? -din : din);
    if (din > HI || din < LO) begin
      dout = {din[IW-1], (OW-1)'(MAG_MAX)};
    end else begin
      dout = {din[IW-1], mag};
    end
  end

endmodule

// File: rtl/vn_update_serial.sv
// Serial variable-node update: accumulates the channel LLR plus DEG check messages,
// then emits DEG extrinsic messages (posterior minus own input) in sign-magnitude.
module vn_update_serial
  import ldpc_pkg::*;
#(
  parameter int DEG = 3,
  parameter int W   = ldpc_pkg::W,
  parameter int AW  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_msg,
  output logic         out_last,
  output logic [W-1:0] out_total,
  output logic         out_hard
);

  localparam int CW = $clog2(DEG + 1);
  localparam int IW = (DEG > 1) ? $clog2(DEG) : 1;

  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic signed [AW-1:0] acc;
  logic [W-1:0]         msg_buf [DEG];

  logic                 in_fire;
  logic                 out_fire;
  logic                 last_idx;
  logic [W-1:0]         own_msg;
  logic signed [AW:0]   diff;
  logic signed [AW:0]   total;
  logic [W-1:0]         msg_sm;
  logic [W-1:0]         total_sm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && cnt == CW'(DEG)) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && last_idx) begin
          state_next = ACC;
        end
      end
      default: state_next = ACC;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_idx = (idx == IW'(DEG - 1));

  // Beat 0 is the channel LLR and only feeds the sum; beats 1..DEG are kept for the extrinsic step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      acc <= '0;
    end else begin
      if (in_fire) begin
        acc <= acc + {{(AW-W){in_data[W-1]}}, in_data};
        cnt <= (cnt == CW'(DEG)) ? '0 : cnt + 1'b1;
      end
      if (out_fire) begin
        if (last_idx) begin
          idx <= '0;
          acc <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire && cnt != '0) begin
      msg_buf[IW'(cnt - 1'b1)] <= in_data;
    end
  end

  assign own_msg = msg_buf[idx];
  assign diff    = {acc[AW-1], acc} - {{(AW+1-W){own_msg[W-1]}}, own_msg};
  assign total   = {acc[AW-1], acc};

  sat_t_to_s #(.IW(AW + 1), .OW(W)) u_sat_msg (
    .din  (diff),
    .dout (msg_sm)
  );

  sat_t_to_s #(.IW(AW + 1), .OW(W)) u_sat_total (
    .din  (total),
    .dout (total_sm)
  );

  // Outputs are forced to zero outside EMIT so the unreset buffer never leaks out.
  assign out_msg   = out_valid ? msg_sm : '0;
  assign out_total = out_valid ? total_sm : '0;
  assign out_hard  = out_valid & acc[AW-1];
  assign out_last  = out_valid & last_idx;

endmodule

// File: tb/tb_vn_update_serial.sv
// Self-checking bench for vn_update_serial (DEG=3): a block-level model predicts each
// extrinsic message from the plain integer sum, and a monitor compares every cycle.
module tb_vn_update_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_data = '0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_msg;
  logic       out_last;
  logic [4:0] out_total;
  logic       out_hard;

  typedef struct {
    logic [4:0] msg;
    logic       last;
    logic [4:0] total;
    logic       hard;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  vn_update_serial #(.DEG(3), .W(5), .AW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_msg   (out_msg),
    .out_last  (out_last),
    .out_total (out_total),
    .out_hard  (out_hard)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] sat2sm(input int v);
    int c;
    c = (v > 15) ? 15 : ((v < -15) ? -15 : v);
    if (c < 0) return {1'b1, 4'(-c)};
    return {1'b0, 4'(c)};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Drives the four beats of one block and, once the last is accepted, queues the three
  // expected extrinsic messages computed from the integer sum.
  task automatic applyStimulus(input int llr, input int m1, input int m2, input int m3,
                               input bit gaps);
    int   beats[4];
    int   sum;
    exp_t e;
    beats = '{llr, m1, m2, m3};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 5'(beats[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gaps && i < 3) begin
        @(posedge clk); #1;
      end
    end
    sum = llr + m1 + m2 + m3;
    for (int i = 1; i < 4; i++) begin
      e.msg   = sat2sm(sum - beats[i]);
      e.last  = (i == 3);
      e.total = sat2sm(sum);
      e.hard  = (sum < 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic drainOutputs();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_done", {7'b0, exp_q.size() == 0}, 8'd1);
    exp_q.delete();
    #1;
  endtask

  // Per-cycle compare: the unit must be emitting exactly while the model holds messages.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      checkOutput("in_ready", {7'b0, in_ready}, {7'b0, exp_q.size() == 0});
      checkOutput("out_valid", {7'b0, out_valid}, {7'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        checkOutput("out_msg", {3'b0, out_msg}, {3'b0, exp_q[0].msg});
        checkOutput("out_last", {7'b0, out_last}, {7'b0, exp_q[0].last});
        checkOutput("out_total", {3'b0, out_total}, {3'b0, exp_q[0].total});
        checkOutput("out_hard", {7'b0, out_hard}, {7'b0, exp_q[0].hard});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {7'b0, in_ready}, 8'd1);
    checkOutput("rst_out_valid", {7'b0, out_valid}, 8'd0);
    checkOutput("rst_out_msg", {3'b0, out_msg}, 8'd0);
    checkOutput("rst_out_total", {3'b0, out_total}, 8'd0);
    rst_n = 1'b1;

    applyStimulus(3, 2, -5, 4, 1'b0);
    @(negedge clk);
    checkOutput("s1_msg0", {3'b0, out_msg}, 8'b00010);
    checkOutput("s1_total", {3'b0, out_total}, 8'b00100);
    drainOutputs();

    applyStimulus(15, 15, 15, 15, 1'b0);
    @(negedge clk);
    checkOutput("s2_msg0", {3'b0, out_msg}, 8'b01111);
    checkOutput("s2_total", {3'b0, out_total}, 8'b01111);
    drainOutputs();

    applyStimulus(-7, -1, -2, 1, 1'b0);
    @(negedge clk);
    checkOutput("s3_msg0", {3'b0, out_msg}, 8'b11000);
    checkOutput("s3_total", {3'b0, out_total}, 8'b11001);
    checkOutput("s3_hard", {7'b0, out_hard}, 8'd1);
    drainOutputs();

    // Stall at idx 1 while junk beats are offered on the input side.
    applyStimulus(3, 2, -5, 4, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 5'(7 - i);
      @(posedge clk); #1;
    end
    checkOutput("bp_msg1", {3'b0, out_msg}, 8'b01001);
    checkOutput("bp_in_ready", {7'b0, in_ready}, 8'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drainOutputs();

    applyStimulus(0, 1, -1, 0, 1'b1);
    @(negedge clk);
    checkOutput("gap_msg0", {3'b0, out_msg}, 8'b10001);
    checkOutput("gap_total", {3'b0, out_total}, 8'b00000);
    drainOutputs();

    // Abort a block after two beats.
    in_valid = 1'b1;
    in_data  = 5'd5;
    @(posedge clk); #1;
    in_data  = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("abort_in_ready", {7'b0, in_ready}, 8'd1);
    checkOutput("abort_out_valid", {7'b0, out_valid}, 8'd0);
    checkOutput("abort_out_msg", {3'b0, out_msg}, 8'd0);
    checkOutput("abort_out_last", {7'b0, out_last}, 8'd0);
    checkOutput("abort_out_hard", {7'b0, out_hard}, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1, 1, 1, 1, 1'b0);
    @(negedge clk);
    checkOutput("post_msg0", {3'b0, out_msg}, 8'b00011);
    checkOutput("post_total", {3'b0, out_total}, 8'b00100);
    drainOutputs();

    repeat (2) @(posedge clk);
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
